// File: rtl/lsu_ctrl_if.sv
// Bundle of pipeline request/response and load/store datapath signals for lsu_ctrl.
// slave = the controller, master = the pipeline plus datapath side.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        lsu_read;
    logic        lsu_write;
    logic        lsu_mem;
    logic        lsu_uart;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_get;
    logic        tx_full;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  lsu_rdata, lsu_get, tx_full,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output lsu_read, lsu_write, lsu_mem, lsu_uart, lsu_addr, lsu_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output lsu_rdata, lsu_get, tx_full,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  lsu_read, lsu_write, lsu_mem, lsu_uart, lsu_addr, lsu_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: decodes one request at a time onto the 1 KB word memory or UART window,
// does read-modify-write for sub-word stores. Define LSU_TIMEOUT_EN to bound the UART wait states.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCESS, S_RMW_RD, S_RMW_WR, S_TX_WAIT, S_RX_WAIT, S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        lsu_read_q, lsu_read_d;
    logic        lsu_write_q, lsu_write_d;
    logic        lsu_mem_q, lsu_mem_d;
    logic        lsu_uart_q, lsu_uart_d;
    logic [31:0] lsu_addr_q, lsu_addr_d;
    logic [31:0] lsu_wdata_q, lsu_wdata_d;
    logic        timed_out;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timed_out = 1'b0;
`endif

    logic       is_mem, is_uart, misaligned, dec_err;
    logic [1:0] reg_sel;

    assign is_mem     = (bus.req_addr < 32'h0000_0400);
    assign is_uart    = (bus.req_addr[31:4] == 28'h000_0040);
    assign reg_sel    = bus.req_addr[3:2];
    assign misaligned = (bus.req_size == 2'd3)
                     || (bus.req_size == 2'd1 && bus.req_addr[0])
                     || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
    assign dec_err    = !(is_mem || is_uart) || misaligned
                     || (is_uart && bus.req_size != 2'd2)
                     || (is_uart && bus.req_we && (reg_sel == 2'd1 || reg_sel == 2'd2));

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = {{24{b[7] & ~uns}}, b};
            2'd1:    r = {{16{h[15] & ~uns}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] wd,
                                               input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] r;
        r = w;
        if (size == 2'd0) r[{lane, 3'b000} +: 8]     = wd[7:0];
        else              r[{lane[1], 4'b0000} +: 16] = wd[15:0];
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        lsu_read_d  = 1'b0;
        lsu_write_d = 1'b0;
        lsu_mem_d   = 1'b0;
        lsu_uart_d  = 1'b0;
        lsu_addr_d  = lsu_addr_q;
        lsu_wdata_d = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef LSU_TIMEOUT_EN
        wait_cnt_d  = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    lane_d     = bus.req_addr[1:0];
                    size_d     = bus.req_size;
                    uns_d      = bus.req_unsigned;
                    we_d       = bus.req_we;
                    wdata_d    = bus.req_wdata;
                    err_d      = dec_err;
                    data_d     = '0;
                    lsu_addr_d = is_mem ? {24'd0, bus.req_addr[9:2]} : bus.req_addr;
                    if (dec_err) begin
                        state_d = S_RESP;
                    end else if (is_mem) begin
                        lsu_mem_d = 1'b1;
                        if (bus.req_we && bus.req_size != 2'd2) begin
                            state_d    = S_RMW_RD;
                            lsu_read_d = 1'b1;
                        end else begin
                            state_d     = S_ACCESS;
                            lsu_read_d  = !bus.req_we;
                            lsu_write_d = bus.req_we;
                            lsu_wdata_d = bus.req_we ? bus.req_wdata : '0;
                        end
                    end else if (bus.req_we && reg_sel == 2'd0) begin
                        state_d = S_TX_WAIT;
                    end else if (!bus.req_we && reg_sel == 2'd1) begin
                        state_d    = S_RX_WAIT;
                        lsu_read_d = 1'b1;
                        lsu_uart_d = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        lsu_uart_d  = 1'b1;
                        lsu_read_d  = !bus.req_we;
                        lsu_write_d = bus.req_we;
                        lsu_wdata_d = bus.req_we ? bus.req_wdata : '0;
                    end
                end
            end
            S_ACCESS: begin
                // Word-sized UART reads pass through load_extract unchanged.
                if (!we_q) data_d = load_extract(bus.lsu_rdata, lane_q, size_q, uns_q);
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                data_d      = bus.lsu_rdata;
                lsu_write_d = 1'b1;
                lsu_mem_d   = 1'b1;
                lsu_wdata_d = lane_merge(bus.lsu_rdata, wdata_q, lane_q, size_q);
                state_d     = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_TX_WAIT: begin
                if (!bus.tx_full) begin
                    lsu_write_d = 1'b1;
                    lsu_uart_d  = 1'b1;
                    lsu_wdata_d = wdata_q;
                    state_d     = S_RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            S_RX_WAIT: begin
                if (bus.lsu_get) begin
                    data_d  = bus.lsu_rdata;
                    state_d = S_RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = S_RESP;
                end else begin
                    lsu_read_d = 1'b1;
                    lsu_uart_d = 1'b1;
`ifdef LSU_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (we_q || err_q) ? '0 : data_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            data_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            lsu_read_q  <= 1'b0;
            lsu_write_q <= 1'b0;
            lsu_mem_q   <= 1'b0;
            lsu_uart_q  <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            lsu_read_q  <= lsu_read_d;
            lsu_write_q <= lsu_write_d;
            lsu_mem_q   <= lsu_mem_d;
            lsu_uart_q  <= lsu_uart_d;
            lsu_addr_q  <= lsu_addr_d;
            lsu_wdata_q <= lsu_wdata_d;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.lsu_read  = lsu_read_q;
    assign bus.lsu_write = lsu_write_q;
    assign bus.lsu_mem   = lsu_mem_q;
    assign bus.lsu_uart  = lsu_uart_q;
    assign bus.lsu_addr  = lsu_addr_q;
    assign bus.lsu_wdata = lsu_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-level reference memory predicts load data, errors,
// latency and strobe counts; a negedge monitor pops expectations on every rsp_valid.
module tb_lsu_ctrl;

    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned n_reads = 0, n_writes = 0, n_rsp = 0;
    int unsigned rsp_cyc = 0, last_wr_cyc = 0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic [31:0] uart_val = '0;
    logic [31:0] dp_mem [256] = '{default: '0};
    logic [7:0]  ref_b [1024] = '{default: '0};

    // Datapath stand-in: word memory behind lsu_mem, a single UART read value otherwise.
    assign bus.lsu_rdata = bus.lsu_mem ? dp_mem[bus.lsu_addr[7:0]] : uart_val;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.lsu_write && bus.lsu_mem) dp_mem[bus.lsu_addr[7:0]] <= bus.lsu_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.lsu_read) n_reads++;
            if (bus.lsu_write) begin
                n_writes++;
                last_wr_cyc = cyc;
                last_wdata  = bus.lsu_wdata;
            end
            if (bus.lsu_read || bus.lsu_write) last_addr = bus.lsu_addr;
            if (bus.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                end
                rsp_cyc = cyc;
                n_rsp++;
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned n, input logic [31:0] uval);
        int unsigned nb, lat, rd, wr, acc, rd0, wr0, rsp0;
        logic        in_mem, in_uart, err, is_tx, is_rx;
        logic [31:0] v, exp_addr;
        nb      = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
        in_mem  = addr < 32'd1024;
        in_uart = addr >= 32'd1024 && addr < 32'd1040;
        err     = (nb == 0);
        if (!err)
            err = (addr % nb) != 0 || !(in_mem || in_uart) || (in_uart && nb != 4)
               || (in_uart && we && (addr == 32'h404 || addr == 32'h408));
        is_tx    = !err && in_uart && we && addr == 32'h400;
        is_rx    = !err && in_uart && !we && addr == 32'h404;
        exp_addr = in_mem ? addr / 4 : addr;
        v = '0;
        if (err) begin
            lat = 1; rd = 0; wr = 0;
        end else if (in_mem && we) begin
            for (int unsigned i = 0; i < nb; i++) ref_b[addr + i] = 8'(wdata >> (8 * i));
            lat = (nb == 4) ? 2 : 3; wr = 1; rd = (nb == 4) ? 0 : 1;
        end else if (in_mem) begin
            for (int unsigned i = 0; i < nb; i++) v = v | (32'(ref_b[addr + i]) << (8 * i));
            if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 32'd1) == 32'd1)
                v = v | ~((32'd1 << (8 * nb)) - 32'd1);
            lat = 2; rd = 1; wr = 0;
        end else if (we) begin
            lat = is_tx ? 2 + n : 2; wr = 1; rd = 0;
        end else begin
            v = uval; lat = is_rx ? 2 + n : 2; rd = is_rx ? 1 + n : 1; wr = 0;
        end
        sb_q.push_back('{rdata: v, err: err});

        @(negedge clk);
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        uart_val    = uval;
        bus.tx_full = is_tx && n > 0;
        bus.lsu_get = !(is_rx && n > 0);
        rd0 = n_reads; wr0 = n_writes; rsp0 = n_rsp;
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        bus.req_valid = 1'b0;
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        bus.req_size = 2'($urandom); bus.req_we = 1'($urandom); bus.req_unsigned = 1'($urandom);
        if (is_tx || is_rx) begin
            repeat (n) @(negedge clk);
            bus.tx_full = 1'b0;
            bus.lsu_get = 1'b1;
        end
        for (int i = 0; i < 100 && n_rsp == rsp0; i++) @(negedge clk);
        chk("rsp_seen", {31'd0, n_rsp != rsp0}, 32'd1);
        chk("latency", rsp_cyc - acc, lat);
        chk("read_strobes", n_reads - rd0, rd);
        chk("write_strobes", n_writes - wr0, wr);
        if (!err) chk("lsu_addr", last_addr, exp_addr);
        if (is_tx) begin
            chk("tx_write_to_rsp", rsp_cyc - last_wr_cyc, 32'd1);
            chk("tx_wdata", last_wdata, wdata);
        end
        bus.lsu_get = 1'b0;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int unsigned sel, acc, wr0, rsp0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.lsu_get = 1'b0; bus.tx_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_strobes", {28'd0, bus.lsu_read, bus.lsu_write, bus.lsu_mem, bus.lsu_uart}, 32'd0);
        chk("reset_lsu_addr", bus.lsu_addr, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h011, 32'h123456A5, 0, 32'h0);
        chk("rmw_word", dp_mem[4], 32'hDEADA5EF);
        do_req(1'b0, 2'd0, 1'b0, 32'h011, 32'h0, 0, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h011, 32'h0, 0, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 0, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h41, 5, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 3, 32'h155);
        do_req(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, 0, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h408, 32'h77, 0, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 0, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h400, 32'h0, 0, 32'h0);

`ifdef LSU_TIMEOUT_EN
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        wr0 = n_writes; rsp0 = n_rsp;
        bus.tx_full = 1'b1;
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h400;
        bus.req_wdata = 32'h99; bus.req_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 200 && n_rsp == rsp0; i++) @(negedge clk);
        chk("timeout_rsp_seen", {31'd0, n_rsp != rsp0}, 32'd1);
        chk("timeout_latency", rsp_cyc - acc, 1 + TO);
        chk("timeout_writes", n_writes - wr0, 32'd0);
        bus.tx_full = 1'b0;
`endif

        // Reset while parked in the TX wait state: the pending store must vanish silently.
        @(negedge clk);
        rsp0 = n_rsp;
        bus.tx_full = 1'b1;
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h400;
        bus.req_wdata = 32'h5A; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", {31'd0, bus.req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_mid_strobes", {28'd0, bus.lsu_read, bus.lsu_write, bus.lsu_mem, bus.lsu_uart}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.tx_full = 1'b0;
        repeat (6) @(negedge clk);
        chk("reset_mid_no_rsp", n_rsp - rsp0, 32'd0);

        for (int t = 0; t < 80; t++) begin
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                a = $urandom_range(0, 1023);
                if (sel <= 4 && sz == 2'd1) a = a & ~32'd1;
                if (sel <= 4 && sz == 2'd2) a = a & ~32'd3;
            end else if (sel <= 7) begin
                a = 32'h400 + 4 * $urandom_range(0, 3);
                if (sel == 6) sz = 2'd2;
            end else if (sel == 8) begin
                a = $urandom;
                if (a < 32'd1040) a = a + 32'd2048;
            end else begin
                a = $urandom_range(1024, 1039);
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 50000 cycles");
        $fatal(1, "simulation time limit reached");
    end

endmodule
